// File: rtl/rv32i_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rv32i_regfile_wb_arbiter
//   Owns the single write port of the RV32I register file.
//   - After reset, zero-scrubs x1..x31 because the register file has no reset.
//   - In RUN, round-robin arbitrates write-back between path A (ALU) and
//     path B (load / long-latency).
//   - Keeps a busy scoreboard for path-B destinations and raises hazard so
//     issue logic stalls on RAW/WAW against an outstanding long op.
//
// Ports
//   sys_clk, sys_reset             clock, async active-low reset
//   a_valid/a_rd/a_data/a_ready    ALU write-back request + accept
//   b_valid/b_rd/b_data/b_ready    load write-back request + accept
//   issue_valid/issue_long         instruction presented / completes via B
//   issue_rs1/issue_rs2/issue_rd   operands of the presented instruction
//   hazard                         1 = instruction must not issue this cycle
//   rf_we/rf_rd/rf_indata          register file write port
//   init_done                      1 once the scrub has finished
// ---------------------------------------------------------------------------
module rv32i_regfile_wb_arbiter #(
    parameter int XLEN     = 32,
    parameter bit SCRUB_EN = 1'b1
) (
    input  logic            sys_clk,
    input  logic            sys_reset,
    input  logic            a_valid,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,
    input  logic            issue_valid,
    input  logic            issue_long,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    input  logic [4:0]      issue_rd,
    output logic            hazard,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_indata,
    output logic            init_done
);

    typedef enum logic {SCRUB, RUN} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] busy;
    logic        prio;      // 0: A wins a tie, 1: B wins a tie

    logic        gnt_a, gnt_b;
    logic [31:0] busy_rd;
    logic        hz;

    // x0 is never a real destination, so it never reads busy.
    assign busy_rd = {busy[31:1], 1'b0};

    // Note: a register being cleared by a B grant this cycle still reads busy.
    assign hz = busy_rd[issue_rs1] | busy_rd[issue_rs2] | busy_rd[issue_rd];

    assign gnt_a = (state == RUN) && a_valid && (!b_valid || !prio);
    assign gnt_b = (state == RUN) && b_valid && (!a_valid ||  prio);

    // Outputs are forced inactive while reset is held, independent of state.
    always_comb begin
        rf_we     = 1'b0;
        rf_rd     = '0;
        rf_indata = '0;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        hazard    = 1'b1;
        init_done = 1'b0;
        if (sys_reset) begin
            if (state == SCRUB) begin
                rf_we = 1'b1;
                rf_rd = cnt;
            end else begin
                init_done = 1'b1;
                hazard    = hz;
                a_ready   = gnt_a;
                b_ready   = gnt_b;
                if (gnt_a) begin
                    rf_we     = (a_rd != 5'd0);
                    rf_rd     = a_rd;
                    rf_indata = a_data;
                end else if (gnt_b) begin
                    rf_we     = (b_rd != 5'd0);
                    rf_rd     = b_rd;
                    rf_indata = b_data;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state <= SCRUB_EN ? SCRUB : RUN;
            cnt   <= 5'd1;
            busy  <= '0;
            prio  <= 1'b0;
        end else begin
            case (state)
                SCRUB: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= RUN;
                end
                default: begin
                    // Point priority at whoever lost (or was absent).
                    if (gnt_a)      prio <= 1'b1;
                    else if (gnt_b) prio <= 1'b0;
                    // Clear and set never hit the same index: WAW blocks the set.
                    if (gnt_b && b_rd != 5'd0) busy[b_rd] <= 1'b0;
                    if (issue_valid && issue_long && !hz && issue_rd != 5'd0)
                        busy[issue_rd] <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rv32i_regfile_wb_arbiter
//   Directed steps plus a randomized phase, all checked every cycle against a
//   behavioural model: scrub progress as a cycle count, a busy-bit array and
//   a tie-break flag derived from the arbitration rules.
// ---------------------------------------------------------------------------
module tb_rv32i_regfile_wb_arbiter;

    localparam int XLEN = 32;

    logic            sys_clk = 1'b0;
    logic            sys_reset = 1'b0;
    logic            a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]      a_rd = '0, b_rd = '0;
    logic [XLEN-1:0] a_data = '0, b_data = '0;
    logic            issue_valid = 1'b0, issue_long = 1'b0;
    logic [4:0]      issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0;
    logic            a_ready, b_ready, hazard, rf_we, init_done;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_indata;

    rv32i_regfile_wb_arbiter #(.XLEN(XLEN), .SCRUB_EN(1'b1)) dut (
        .sys_clk(sys_clk), .sys_reset(sys_reset),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .issue_valid(issue_valid), .issue_long(issue_long),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .hazard(hazard), .rf_we(rf_we), .rf_rd(rf_rd), .rf_indata(rf_indata),
        .init_done(init_done)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int scrub_done_cycles = 0;   // scrub writes completed since release
    bit m_b_first = 1'b0;        // 1 when B should win a tie
    bit m_busy [32];

    // Last sampled DUT outputs, for directed checks after a cycle
    logic s_a_ready, s_b_ready, s_hazard, s_we, s_init;
    logic [4:0] s_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_hazard();
        return (issue_rs1 != 0 && m_busy[issue_rs1]) ||
               (issue_rs2 != 0 && m_busy[issue_rs2]) ||
               (issue_rd  != 0 && m_busy[issue_rd]);
    endfunction

    // One clock: inputs are already set (after a negedge); compare, clock, update.
    task automatic cycle();
        bit ga, gb, hz;
        logic [4:0] erd;
        logic [31:0] edat;
        #1;
        s_a_ready = a_ready; s_b_ready = b_ready; s_hazard = hazard;
        s_we = rf_we; s_init = init_done; s_rd = rf_rd;
        ga = 0; gb = 0; hz = m_hazard();
        if (!sys_reset) begin
            chk("rst_we", rf_we, 0);       chk("rst_rd", rf_rd, 0);
            chk("rst_data", rf_indata, 0); chk("rst_ardy", a_ready, 0);
            chk("rst_brdy", b_ready, 0);   chk("rst_haz", hazard, 1);
            chk("rst_init", init_done, 0);
        end else if (scrub_done_cycles < 31) begin
            chk("scr_we", rf_we, 1);
            chk("scr_rd", rf_rd, scrub_done_cycles + 1);
            chk("scr_data", rf_indata, 0);
            chk("scr_ardy", a_ready, 0);   chk("scr_brdy", b_ready, 0);
            chk("scr_haz", hazard, 1);     chk("scr_init", init_done, 0);
        end else begin
            if (a_valid && b_valid) begin ga = !m_b_first; gb = m_b_first; end
            else begin ga = a_valid; gb = b_valid; end
            erd  = ga ? a_rd : (gb ? b_rd : 5'd0);
            edat = ga ? a_data : (gb ? b_data : 32'd0);
            chk("run_ardy", a_ready, ga);  chk("run_brdy", b_ready, gb);
            chk("run_we", rf_we, (ga || gb) && erd != 0);
            chk("run_rd", rf_rd, erd);     chk("run_data", rf_indata, edat);
            chk("run_haz", hazard, hz);    chk("run_init", init_done, 1);
        end
        @(posedge sys_clk);
        if (!sys_reset) begin
            scrub_done_cycles = 0;
            m_b_first = 0;
            foreach (m_busy[i]) m_busy[i] = 0;
        end else if (scrub_done_cycles < 31) begin
            scrub_done_cycles++;
        end else begin
            if (ga) m_b_first = 1;
            if (gb) m_b_first = 0;
            if (gb && b_rd != 0) m_busy[b_rd] = 0;
            if (issue_valid && issue_long && !hz && issue_rd != 0) m_busy[issue_rd] = 1;
        end
        @(negedge sys_clk);
    endtask

    task automatic idle();
        a_valid = 0; b_valid = 0; issue_valid = 0; issue_long = 0;
        issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    endtask

    initial begin
        bit pend_a, pend_b;

        // Reset held: outputs inactive
        @(negedge sys_clk);
        cycle(); cycle();

        // Scrub with an ALU request pending from the first cycle
        a_valid = 1; a_rd = 5'd5; a_data = 32'h1234_5678;
        sys_reset = 1;
        for (int i = 0; i < 31; i++) cycle();
        chk("scrub_last_rd", s_rd, 31);
        chk("scrub_ardy_low", s_a_ready, 0);
        cycle();
        chk("init_cycle32", s_init, 1);
        chk("x5_accept", s_a_ready, 1);
        chk("x5_rd", s_rd, 5);
        idle();

        // Lone B write moves priority back to A
        b_valid = 1; b_rd = 5'd4; b_data = 32'h0000_0044;
        cycle();
        chk("lone_b", s_b_ready, 1);

        // Contention: A,B,A,B
        a_valid = 1; a_rd = 5'd3; a_data = 32'hAAAA_0003;
        b_valid = 1; b_rd = 5'd4; b_data = 32'hBBBB_0004;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("cont_ardy", s_a_ready, (i % 2) == 0);
            chk("cont_brdy", s_b_ready, (i % 2) == 1);
            chk("cont_rd", s_rd, (i % 2) == 0 ? 3 : 4);
        end
        idle();

        // Scoreboard: long op to x7
        issue_valid = 1; issue_long = 1; issue_rd = 5'd7;
        cycle();
        idle(); issue_rs1 = 5'd7; cycle(); chk("sb_rs1_7", s_hazard, 1);
        issue_rs1 = 5'd8; issue_rd = 5'd7; cycle(); chk("sb_waw_7", s_hazard, 1);
        issue_rd = 5'd0; cycle(); chk("sb_rs1_8", s_hazard, 0);
        issue_rs1 = 5'd7; b_valid = 1; b_rd = 5'd7; b_data = 32'h7777_7777;
        cycle(); chk("sb_no_bypass", s_hazard, 1);
        b_valid = 0; cycle(); chk("sb_cleared", s_hazard, 0);
        idle();

        // Set and clear of different indices in the same cycle
        issue_valid = 1; issue_long = 1; issue_rd = 5'd9; cycle();
        issue_rd = 5'd10; b_valid = 1; b_rd = 5'd9; b_data = 32'h9999_0009;
        cycle();
        idle(); b_valid = 0;
        issue_rs1 = 5'd9; cycle(); chk("sc_9_clear", s_hazard, 0);
        issue_rs1 = 5'd0; issue_rs2 = 5'd10; cycle(); chk("sc_10_set", s_hazard, 1);
        idle();

        // rd = 0 requests and issue
        a_valid = 1; a_rd = 5'd0; a_data = 32'hDEAD_BEEF;
        cycle(); chk("rd0_ready", s_a_ready, 1); chk("rd0_we", s_we, 0);
        idle();
        issue_valid = 1; issue_long = 1; issue_rd = 5'd0; cycle();
        chk("rd0_issue_haz", s_hazard, 0);
        idle(); cycle();

        // Randomized phase with requests held until accepted
        pend_a = 0; pend_b = 0;
        for (int n = 0; n < 400; n++) begin
            if (!pend_a) begin
                a_valid = $urandom_range(0, 1); a_rd = 5'($urandom); a_data = $urandom;
            end
            if (!pend_b) begin
                b_valid = $urandom_range(0, 1); b_rd = 5'($urandom); b_data = $urandom;
            end
            issue_valid = $urandom_range(0, 1); issue_long = $urandom_range(0, 1);
            issue_rs1 = 5'($urandom); issue_rs2 = 5'($urandom); issue_rd = 5'($urandom);
            cycle();
            pend_a = a_valid && !s_a_ready;
            pend_b = b_valid && !s_b_ready;
        end

        // Reset in RUN (busy likely non-zero), then a full re-scrub
        idle(); b_valid = 0;
        sys_reset = 0; cycle(); cycle();
        sys_reset = 1;
        for (int i = 0; i < 11; i++) cycle();
        // Reset mid-scrub at cnt=12
        #1 chk("mid_scrub_rd12", rf_rd, 12);
        sys_reset = 0; cycle();
        sys_reset = 1;
        for (int i = 0; i < 31; i++) begin
            cycle();
            if (i == 0) chk("restart_rd1", s_rd, 1);
            chk("restart_init_low", s_init, 0);
        end
        cycle(); chk("restart_init32", s_init, 1);
        // Busy cleared by reset: no hazard on any operand
        for (int r = 1; r < 32; r += 5) begin
            issue_rs1 = 5'(r); issue_rs2 = 5'(r + 1); issue_rd = 5'(r + 2);
            cycle(); chk("post_rst_busy", s_hazard, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
